// File: rtl/nibble_cmp_seq.sv
// Compares two WIDTH-bit operands through one shared 4-bit cascadable comparator slice,
// one nibble per clock, MSB first, stopping at the first unequal nibble.
module nibble_cmp_seq #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt,
    output logic             err,
    output logic [3:0]       cmp_a,
    output logic [3:0]       cmp_b,
    output logic             cmp_eq_in,
    output logic             cmp_gt_in,
    output logic             cmp_lt_in,
    input  logic             cmp_e,
    input  logic             cmp_g,
    input  logic             cmp_l
);

    localparam int unsigned NIB  = WIDTH / 4;
    localparam int unsigned IDXW = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t           state;
    logic [IDXW-1:0]  idx;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;

    assign cmp_eq_in = 1'b1;
    assign cmp_gt_in = 1'b0;
    assign cmp_lt_in = 1'b0;

    // idx is cleared on entering DONE, so IDLE/DONE present nibble 0
    always_comb begin
        cmp_a = ra[3:0];
        cmp_b = rb[3:0];
        for (int i = 0; i < NIB; i++) begin
            if (idx == IDXW'(i)) begin
                cmp_a = ra[4*i +: 4];
                cmp_b = rb[4*i +: 4];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= StIdle;
            idx   <= '0;
            ra    <= '0;
            rb    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            eq    <= 1'b0;
            gt    <= 1'b0;
            lt    <= 1'b0;
            err   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        ra    <= a;
                        rb    <= b;
                        idx   <= IDXW'(NIB - 1);
                        busy  <= 1'b1;
                        state <= StRun;
                    end
                end
                StRun: begin
                    case ({cmp_e, cmp_g, cmp_l})
                        3'b010, 3'b001: begin
                            eq    <= 1'b0;
                            gt    <= cmp_g;
                            lt    <= cmp_l;
                            err   <= 1'b0;
                            idx   <= '0;
                            done  <= 1'b1;
                            state <= StDone;
                        end
                        3'b100: begin
                            if (idx == '0) begin
                                eq    <= 1'b1;
                                gt    <= 1'b0;
                                lt    <= 1'b0;
                                err   <= 1'b0;
                                done  <= 1'b1;
                                state <= StDone;
                            end else begin
                                idx <= idx - IDXW'(1);
                            end
                        end
                        default: begin
                            // slice output was not one-hot
                            eq    <= 1'b0;
                            gt    <= 1'b0;
                            lt    <= 1'b0;
                            err   <= 1'b1;
                            idx   <= '0;
                            done  <= 1'b1;
                            state <= StDone;
                        end
                    endcase
                end
                StDone: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_cmp_seq.sv
// Randomised self-checking bench for nibble_cmp_seq with a behavioural comparator slice
// and a fault override on its e/g/l outputs.
module tb_nibble_cmp_seq;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy, done, eq, gt, lt, err;
    logic [3:0]       cmp_a, cmp_b;
    logic             cmp_eq_in, cmp_gt_in, cmp_lt_in;
    logic             cmp_e, cmp_g, cmp_l;
    logic             fault_on = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    nibble_cmp_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .eq        (eq),
        .gt        (gt),
        .lt        (lt),
        .err       (err),
        .cmp_a     (cmp_a),
        .cmp_b     (cmp_b),
        .cmp_eq_in (cmp_eq_in),
        .cmp_gt_in (cmp_gt_in),
        .cmp_lt_in (cmp_lt_in),
        .cmp_e     (cmp_e),
        .cmp_g     (cmp_g),
        .cmp_l     (cmp_l)
    );

    // Behavioural 4-bit slice with a fault override
    always_comb begin
        {cmp_e, cmp_g, cmp_l} = {cmp_a == cmp_b, cmp_a > cmp_b, cmp_a < cmp_b};
        if (fault_on) {cmp_e, cmp_g, cmp_l} = 3'b110;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Index (0 = MSB) of the first differing nibble, NIB if operands are equal
    function automatic int first_diff(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        for (int k = 0; k < NIB; k++)
            if (x[WIDTH-1-4*k -: 4] != y[WIDTH-1-4*k -: 4]) return k;
        return NIB;
    endfunction

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy) check({tag, "_idle_timeout"}, 32'(busy), 32'd0);
    endtask

    task automatic run_cmp(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                           input int fault_at, input bit spurious, input string tag);
        int  k, exp_lat, exp_nib, n, nib;
        bit  seen, nib_ok;
        logic exp_eq, exp_gt, exp_lt, exp_err;
        k = first_diff(ta, tb_);
        if (fault_at >= 0) begin
            exp_lat = fault_at + 2;
            exp_nib = fault_at + 1;
            {exp_eq, exp_gt, exp_lt, exp_err} = 4'b0001;
        end else begin
            exp_lat = (k == NIB) ? NIB + 1 : k + 2;
            exp_nib = (k == NIB) ? NIB : k + 1;
            exp_eq  = (ta == tb_);
            exp_gt  = (ta > tb_);
            exp_lt  = (ta < tb_);
            exp_err = 1'b0;
        end
        wait_idle(tag);
        a = ta;
        b = tb_;
        start = 1'b1;
        @(posedge clk);
        nib = 0;
        seen = 0;
        nib_ok = 1;
        for (n = 1; n <= NIB + 3; n++) begin
            @(negedge clk);
            start = spurious && (n == 1 || n == 3);
            if (spurious) begin
                a = ~ta;
                b = tb_ + 16'h1111;
            end
            if (done) begin
                seen = 1;
                break;
            end
            if (cmp_a != ta[WIDTH-1-4*nib -: 4] || cmp_b != tb_[WIDTH-1-4*nib -: 4]) nib_ok = 0;
            fault_on = (fault_at >= 0 && nib == fault_at);
            nib++;
        end
        fault_on = 1'b0;
        start = 1'b0;
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_latency"}, 32'(n), 32'(exp_lat));
        check({tag, "_nib_count"}, 32'(nib), 32'(exp_nib));
        check({tag, "_nib_values"}, 32'(nib_ok), 32'd1);
        check({tag, "_result"}, {28'd0, eq, gt, lt, err}, {28'd0, exp_eq, exp_gt, exp_lt, exp_err});
        check({tag, "_busy_in_done"}, 32'(busy), 32'd1);
        @(negedge clk);
        check({tag, "_done_pulse"}, {30'd0, done, busy}, 32'd0);
    endtask

    initial begin
        logic [WIDTH-1:0] ra, rb;
        int t_done[$];
        int cyc, saw;
        int j;

        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {26'd0, busy, done, eq, gt, lt, err}, 32'd0);
        check("reset_cmp_known", 32'($isunknown({cmp_a, cmp_b})), 32'd0);
        check("cascade_const", {29'd0, cmp_eq_in, cmp_gt_in, cmp_lt_in}, 32'b100);
        rst_n = 1'b1;
        @(negedge clk);

        run_cmp(16'hA5A5, 16'hA5A5, -1, 0, "equal");
        run_cmp(16'h7000, 16'h6FFF, -1, 0, "msb_diff");
        run_cmp(16'h1232, 16'h1234, -1, 0, "lsb_diff");
        run_cmp(16'h4321, 16'h4321, -1, 1, "ignore_start");
        run_cmp(16'h1234, 16'h1234, 1, 0, "fault");
        run_cmp(16'h1234, 16'h1235, -1, 0, "fault_clear");

        // Back-to-back with start held: accepted only once idle, new operands after done
        wait_idle("b2b");
        a = 16'h7000;
        b = 16'h6FFF;
        start = 1'b1;
        cyc = 0;
        while (t_done.size() < 2 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                t_done.push_back(cyc);
                if (t_done.size() == 1) begin
                    check("b2b_first_gt", {29'd0, eq, gt, lt}, 32'b010);
                    b = 16'h8000;
                end else begin
                    check("b2b_second_lt", {29'd0, eq, gt, lt}, 32'b001);
                end
            end
        end
        start = 1'b0;
        check("b2b_done_count", 32'(t_done.size()), 32'd2);
        if (t_done.size() == 2) check("b2b_spacing", 32'(t_done[1] - t_done[0]), 32'd3);

        // Reset in the middle of a comparison
        wait_idle("rst");
        a = 16'hA5A5;
        b = 16'hA5A5;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check("midrun_reset", {26'd0, busy, done, eq, gt, lt, err}, 32'd0);
        check("midrun_cmp_known", 32'($isunknown({cmp_a, cmp_b})), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw = 0;
        repeat (8) begin
            @(negedge clk);
            if (done || busy) saw++;
        end
        check("no_done_after_reset", 32'(saw), 32'd0);
        run_cmp(16'h0010, 16'h0001, -1, 0, "after_reset");

        // Randomised operands with controlled first-difference position
        for (int it = 0; it < 30; it++) begin
            ra = 16'($urandom);
            rb = ra;
            j = $urandom_range(0, NIB - 1);
            case ($urandom_range(0, 3))
                0: rb = ra;
                3: rb = 16'($urandom);
                default: rb[4*j +: 4] = ra[4*j +: 4] ^ 4'($urandom_range(1, 15));
            endcase
            run_cmp(ra, rb, -1, 0, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

endmodule
